csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 36 +++
 rtl/csr_counter.sv | 25 ++
 rtl/csr_unit.sv | 209 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: addresses, mstatus bit
// positions, write-operation encodings and interrupt cause codes.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // CSR write operations
  typedef enum logic [1:0] {
    WOP_NONE  = 2'b00,
    WOP_WRITE = 2'b01,
    WOP_SET   = 2'b10,
    WOP_CLEAR = 2'b11
  } wop_e;

  // Interrupt cause codes; they double as the mip/mie bit positions
  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-bit counter with a CSR write port that overrides the
// increment in the cycle it is used.
module csr_counter
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count
);

  // Count register: a write wins over the increment; wraps naturally.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (wen) count <= wdata;
    else if (inc) count <= count + XLEN'(1);
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: read port, write/set/clear port, trap entry and
// mret sequencing, interrupt pending/cause generation and the two counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter bit              HAS_COUNTERS = 1,
  parameter logic [XLEN-1:0] MTVEC_RST    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o,
  input  logic            wen_i,
  input  logic [11:0]     waddr_i,
  input  logic [1:0]      wop_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  input  logic            irq_sw_i,
  output logic [XLEN-1:0] trap_pc_o,
  output logic            irq_pend_o,
  output logic [XLEN-1:0] irq_cause_o
);

  // Read-only mstatus content: MPP=11 and, on RV64, UXL/SXL=2
  localparam logic [63:0] MSTATUS_FIXED_64 =
    (XLEN == 64) ? 64'h0000_000A_0000_1800 : 64'h0000_0000_0000_1800;
  localparam logic [XLEN-1:0] MSTATUS_FIXED = MSTATUS_FIXED_64[XLEN-1:0];

  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle, minstret;
  logic            mip_meip, mip_mtip, mip_msip;
  logic [XLEN-1:0] mstatus_val, mip_val, pend_bits, tvec_base;
  logic [XLEN-1:0] wold, wval;
  logic            we;
  wop_e            wop;

  assign wop = wop_e'(wop_i);

  function automatic logic csr_hit(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Assemble the composite CSR views from their stored fields
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mstatus_val               = MSTATUS_FIXED;
    mstatus_val[MSTATUS_MIE]  = mst_mie;
    mstatus_val[MSTATUS_MPIE] = mst_mpie;
    mip_val                   = '0;
    mip_val[IRQ_MEI]          = mip_meip;
    mip_val[IRQ_MTI]          = mip_mtip;
    mip_val[IRQ_MSI]          = mip_msip;
    pend_bits                 = mie_q & mip_val;
    tvec_base                 = {mtvec_q[XLEN-1:2], 2'b00};
  end

  function automatic logic [XLEN-1:0] csr_mux(input logic [11:0] addr,
      input logic [XLEN-1:0] mst, input logic [XLEN-1:0] mip);
    case (addr)
      CSR_MSTATUS:  return mst;
      CSR_MIE:      return mie_q;
      CSR_MTVEC:    return mtvec_q;
      CSR_MSCRATCH: return mscratch_q;
      CSR_MEPC:     return mepc_q;
      CSR_MCAUSE:   return mcause_q;
      CSR_MTVAL:    return mtval_q;
      CSR_MIP:      return mip;
      CSR_MCYCLE:   return mcycle;
      CSR_MINSTRET: return minstret;
      default:      return '0;
    endcase
  endfunction

  // Write-port read-modify-write value
  always_comb begin
    wold = csr_mux(waddr_i, mstatus_val, mip_val);
    case (wop)
      WOP_WRITE: wval = wdata_i;
      WOP_SET:   wval = wold | wdata_i;
      WOP_CLEAR: wval = wold & ~wdata_i;
      default:   wval = wold;
    endcase
    we = wen_i && (wop != WOP_NONE) && csr_hit(waddr_i);
  end

  // Externally visible outputs, all forced to zero while reset is held
  always_comb begin
    rdata_o     = '0;
    illegal_o   = 1'b0;
    trap_pc_o   = '0;
    irq_pend_o  = 1'b0;
    irq_cause_o = '0;
    if (!rst) begin
      rdata_o    = csr_mux(raddr_i, mstatus_val, mip_val);
      illegal_o  = !csr_hit(raddr_i);
      irq_pend_o = mst_mie && (|pend_bits);
      if (pend_bits[IRQ_MEI])      irq_cause_o = {1'b1, (XLEN-1)'(IRQ_MEI)};
      else if (pend_bits[IRQ_MSI]) irq_cause_o = {1'b1, (XLEN-1)'(IRQ_MSI)};
      else if (pend_bits[IRQ_MTI]) irq_cause_o = {1'b1, (XLEN-1)'(IRQ_MTI)};
      if (trap_i) begin
        // Shifting out the interrupt flag leaves 4*cause[XLEN-2:0]
        if (mtvec_q[0] && trap_cause_i[XLEN-1])
          trap_pc_o = tvec_base + (trap_cause_i << 2);
        else
          trap_pc_o = tvec_base;
      end else if (mret_i) begin
        trap_pc_o = mepc_q;
      end
    end
  end

  // mstatus interrupt-enable stack: trap beats mret beats CSR write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (trap_i) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret_i) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (we && waddr_i == CSR_MSTATUS) begin
      mst_mie  <= wval[MSTATUS_MIE];
      mst_mpie <= wval[MSTATUS_MPIE];
    end
  end

  // Trap-capture registers: a trap overrides a same-cycle CSR write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_i) begin
      mepc_q   <= {trap_epc_i[XLEN-1:2], 2'b00};
      mcause_q <= trap_cause_i;
      mtval_q  <= trap_tval_i;
    end else if (we) begin
      if (waddr_i == CSR_MEPC)   mepc_q   <= {wval[XLEN-1:2], 2'b00};
      if (waddr_i == CSR_MCAUSE) mcause_q <= wval;
      if (waddr_i == CSR_MTVAL)  mtval_q  <= wval;
    end
  end

  // Plain software-written registers; mtvec bit 1 is reserved as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
    end else if (we) begin
      if (waddr_i == CSR_MIE)      mie_q      <= wval;
      if (waddr_i == CSR_MTVEC)    mtvec_q    <= {wval[XLEN-1:2], 1'b0, wval[0]};
      if (waddr_i == CSR_MSCRATCH) mscratch_q <= wval;
    end
  end

  // Sample the level interrupt lines into mip once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip_meip <= 1'b0;
      mip_mtip <= 1'b0;
      mip_msip <= 1'b0;
    end else begin
      mip_meip <= irq_ext_i;
      mip_mtip <= irq_timer_i;
      mip_msip <= irq_sw_i;
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    csr_counter #(.XLEN(XLEN)) u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wen   (we && waddr_i == CSR_MCYCLE),
      .wdata (wval),
      .count (mcycle)
    );
    csr_counter #(.XLEN(XLEN)) u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire_i),
      .wen   (we && waddr_i == CSR_MINSTRET),
      .wdata (wval),
      .count (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (XLEN=64, counters present).
module tb_csr_unit;
  import csr_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [11:0]     raddr_i, waddr_i;
  logic [XLEN-1:0] rdata_o, wdata_i;
  logic            illegal_o, wen_i;
  logic [1:0]      wop_i;
  logic            trap_i, mret_i, retire_i;
  logic [XLEN-1:0] trap_cause_i, trap_epc_i, trap_tval_i;
  logic            irq_timer_i, irq_ext_i, irq_sw_i;
  logic [XLEN-1:0] trap_pc_o, irq_cause_o;
  logic            irq_pend_o;

  int n_cmp = 0;
  int n_bad = 0;

  csr_unit #(.XLEN(XLEN), .HAS_COUNTERS(1), .MTVEC_RST('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
    .illegal_o    (illegal_o),
    .wen_i        (wen_i),
    .waddr_i      (waddr_i),
    .wop_i        (wop_i),
    .wdata_i      (wdata_i),
    .trap_i       (trap_i),
    .trap_cause_i (trap_cause_i),
    .trap_epc_i   (trap_epc_i),
    .trap_tval_i  (trap_tval_i),
    .mret_i       (mret_i),
    .retire_i     (retire_i),
    .irq_timer_i  (irq_timer_i),
    .irq_ext_i    (irq_ext_i),
    .irq_sw_i     (irq_sw_i),
    .trap_pc_o    (trap_pc_o),
    .irq_pend_o   (irq_pend_o),
    .irq_cause_o  (irq_cause_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read a CSR now (inputs settle combinationally)
  task automatic peek(input logic [11:0] addr, input logic [63:0] exp, input string tag);
    raddr_i = addr;
    #1;
    check(tag, rdata_o, exp);
  endtask

  // One-cycle CSR write issued at a falling edge; returns at the next falling edge
  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] data);
    @(negedge clk);
    wen_i = 1'b1; waddr_i = addr; wop_i = op; wdata_i = data;
    @(negedge clk);
    wen_i = 1'b0; wop_i = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    raddr_i = CSR_MSTATUS; waddr_i = '0; wen_i = 1'b0; wop_i = 2'b00; wdata_i = '0;
    trap_i = 1'b0; mret_i = 1'b0; retire_i = 1'b0;
    trap_cause_i = '0; trap_epc_i = '0; trap_tval_i = '0;
    irq_timer_i = 1'b0; irq_ext_i = 1'b0; irq_sw_i = 1'b0;

    // Outputs held at zero during reset
    #5;
    check("rst_rdata", rdata_o, 64'h0);
    raddr_i = 12'h7C0;
    #1;
    check("rst_illegal", {63'h0, illegal_o}, 64'h0);
    check("rst_irq_pend", {63'h0, irq_pend_o}, 64'h0);

    @(negedge clk);
    rst = 1'b0;
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1800, "mstatus_reset");
    peek(CSR_MTVEC, 64'h0, "mtvec_reset");

    // No bypass: a write is invisible in its own cycle
    @(negedge clk);
    wen_i = 1'b1; waddr_i = CSR_MSCRATCH; wop_i = 2'b01; wdata_i = 64'hFF;
    peek(CSR_MSCRATCH, 64'h0, "no_bypass");
    @(negedge clk);
    wen_i = 1'b0; wop_i = 2'b00;
    peek(CSR_MSCRATCH, 64'hFF, "mscratch_write");
    csr_wr(CSR_MSCRATCH, 2'b11, 64'h0F);
    peek(CSR_MSCRATCH, 64'hF0, "mscratch_clear");

    csr_wr(CSR_MTVEC, 2'b01, 64'h8000_0100);
    peek(CSR_MTVEC, 64'h8000_0100, "mtvec_write");
    csr_wr(CSR_MTVEC, 2'b01, 64'h8000_0103);
    peek(CSR_MTVEC, 64'h8000_0101, "mtvec_bit1_zero");

    csr_wr(CSR_MSTATUS, 2'b10, 64'h8);
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1808, "mstatus_set_mie");
    csr_wr(CSR_MSTATUS, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1888, "mstatus_mask");
    csr_wr(CSR_MSTATUS, 2'b11, 64'h80);
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1808, "mstatus_clear_mpie");

    csr_wr(CSR_MEPC, 2'b01, 64'h8000_0043);
    peek(CSR_MEPC, 64'h8000_0040, "mepc_align");
    csr_wr(CSR_MIP, 2'b01, 64'hFFF);
    peek(CSR_MIP, 64'h0, "mip_readonly");
    check("mip_legal", {63'h0, illegal_o}, 64'h0);
    peek(12'h7C0, 64'h0, "unimpl_rdata");
    check("unimpl_illegal", {63'h0, illegal_o}, 64'h1);

    // Interrupts: one cycle of mip latency, then priority ext > sw > timer
    csr_wr(CSR_MIE, 2'b01, 64'h80);
    irq_timer_i = 1'b1;
    #1;
    check("irq_latency", {63'h0, irq_pend_o}, 64'h0);
    @(negedge clk);
    #1;
    check("irq_timer_pend", {63'h0, irq_pend_o}, 64'h1);
    check("irq_timer_cause", irq_cause_o, 64'h8000_0000_0000_0007);
    irq_ext_i = 1'b1;
    csr_wr(CSR_MIE, 2'b01, 64'h880);
    #1;
    check("irq_ext_cause", irq_cause_o, 64'h8000_0000_0000_000B);
    irq_ext_i = 1'b0; irq_sw_i = 1'b1;
    csr_wr(CSR_MIE, 2'b01, 64'h888);
    #1;
    check("irq_sw_cause", irq_cause_o, 64'h8000_0000_0000_0003);
    peek(CSR_MIP, 64'h88, "mip_value");

    // Trap entry, vectored mode, with a competing mepc write
    csr_wr(CSR_MTVEC, 2'b01, 64'h8000_0101);
    @(negedge clk);
    trap_i = 1'b1; trap_cause_i = 64'h2; trap_epc_i = 64'h8000_1234; trap_tval_i = 64'h55;
    #1;
    check("trap_pc_exception", trap_pc_o, 64'h8000_0100);
    trap_cause_i = 64'h8000_0000_0000_0007;
    wen_i = 1'b1; waddr_i = CSR_MEPC; wop_i = 2'b01; wdata_i = 64'h1111_0000;
    #1;
    check("trap_pc_vectored", trap_pc_o, 64'h8000_011C);
    @(negedge clk);
    trap_i = 1'b0; wen_i = 1'b0; wop_i = 2'b00;
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1880, "trap_mstatus");
    peek(CSR_MEPC, 64'h8000_1234, "trap_mepc_wins");
    check("trap_masks_irq", {63'h0, irq_pend_o}, 64'h0);
    peek(CSR_MCAUSE, 64'h8000_0000_0000_0007, "trap_mcause");
    peek(CSR_MTVAL, 64'h55, "trap_mtval");

    // mret beats a same-cycle mstatus write
    csr_wr(CSR_MEPC, 2'b01, 64'h8000_0040);
    @(negedge clk);
    mret_i = 1'b1;
    wen_i = 1'b1; waddr_i = CSR_MSTATUS; wop_i = 2'b11; wdata_i = 64'h88;
    #1;
    check("mret_pc", trap_pc_o, 64'h8000_0040);
    @(negedge clk);
    mret_i = 1'b0; wen_i = 1'b0; wop_i = 2'b00;
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1888, "mret_mstatus");
    check("mret_irq_pend", {63'h0, irq_pend_o}, 64'h1);

    // mret does not block a write to an unrelated register
    @(negedge clk);
    mret_i = 1'b1;
    wen_i = 1'b1; waddr_i = CSR_MSCRATCH; wop_i = 2'b01; wdata_i = 64'h1234;
    @(negedge clk);
    mret_i = 1'b0; wen_i = 1'b0; wop_i = 2'b00;
    peek(CSR_MSCRATCH, 64'h1234, "mret_other_write");

    // Direct mode ignores the interrupt cause; idle trap_pc is zero
    csr_wr(CSR_MTVEC, 2'b01, 64'h8000_0200);
    trap_i = 1'b1; trap_cause_i = 64'h8000_0000_0000_000B;
    #1;
    check("trap_pc_direct", trap_pc_o, 64'h8000_0200);
    trap_i = 1'b0;
    #1;
    check("trap_pc_idle", trap_pc_o, 64'h0);

    // Counters
    csr_wr(CSR_MCYCLE, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    peek(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_write");
    @(negedge clk);
    peek(CSR_MCYCLE, 64'h0, "mcycle_wrap");
    @(negedge clk);
    peek(CSR_MCYCLE, 64'h1, "mcycle_inc");
    csr_wr(CSR_MINSTRET, 2'b01, 64'h5);
    retire_i = 1'b1;
    repeat (3) @(negedge clk);
    retire_i = 1'b0;
    peek(CSR_MINSTRET, 64'h8, "minstret_retire");
    @(negedge clk);
    wen_i = 1'b1; waddr_i = CSR_MINSTRET; wop_i = 2'b01; wdata_i = 64'd100; retire_i = 1'b1;
    @(negedge clk);
    wen_i = 1'b0; wop_i = 2'b00; retire_i = 1'b0;
    peek(CSR_MINSTRET, 64'd100, "minstret_write_wins");
    csr_wr(CSR_MINSTRET, 2'b10, 64'h3);
    peek(CSR_MINSTRET, 64'd103, "minstret_set");

    // Reset in the middle of a trap
    @(negedge clk);
    trap_i = 1'b1; trap_cause_i = 64'h8000_0000_0000_0007; trap_epc_i = 64'h9000;
    #2;
    rst = 1'b1;
    raddr_i = CSR_MSTATUS;
    #1;
    check("midrst_rdata", rdata_o, 64'h0);
    check("midrst_trap_pc", trap_pc_o, 64'h0);
    check("midrst_irq_pend", {63'h0, irq_pend_o}, 64'h0);
    check("midrst_irq_cause", irq_cause_o, 64'h0);
    raddr_i = 12'h7C0;
    #1;
    check("midrst_illegal", {63'h0, illegal_o}, 64'h0);
    @(negedge clk);
    trap_i = 1'b0;
    rst = 1'b0;
    peek(CSR_MSTATUS, 64'h0000_000A_0000_1800, "post_rst_mstatus");
    peek(CSR_MTVEC, 64'h0, "post_rst_mtvec");
    peek(CSR_MEPC, 64'h0, "post_rst_mepc");
    peek(CSR_MSCRATCH, 64'h0, "post_rst_mscratch");
    peek(CSR_MIE, 64'h0, "post_rst_mie");
    peek(CSR_MCYCLE, 64'h0, "post_rst_mcycle");
    peek(CSR_MINSTRET, 64'h0, "post_rst_minstret");
    peek(CSR_MCAUSE, 64'h0, "post_rst_mcause");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
